// File: rtl/pic_pkg.sv
// Shared types, constants and rotating-priority helpers for the 8259 request/in-service stage.
package pic_pkg;

    localparam int NUM_IRQ = 8;
    localparam int LVL_W   = 3;

    typedef logic [LVL_W-1:0] lvl_t;

    localparam lvl_t LP_RESET = 3'd7;

    // Highest-priority set bit of vec, where level lp+1 is highest and lp is lowest; 7 if vec is empty.
    function automatic lvl_t rot_prio_first(input logic [NUM_IRQ-1:0] vec, input lvl_t lp);
        lvl_t idx;
        lvl_t res;
        res = LP_RESET;
        for (int i = NUM_IRQ; i >= 1; i--) begin
            idx = lp + lvl_t'(i);
            if (vec[idx]) res = idx;
        end
        return res;
    endfunction

    // Distance from the top of the priority order; smaller rank means higher priority.
    function automatic lvl_t prio_rank(input lvl_t lvl, input lvl_t lp);
        return lvl - lp - lvl_t'(1);
    endfunction

endpackage

// File: rtl/pic_irq_resolver_if.sv
// Signal bundle between the request/in-service stage (slave) and the PIC control logic (master).
interface pic_irq_resolver_if;
    import pic_pkg::*;

    logic [NUM_IRQ-1:0] ir_in;
    logic               ltim;
    logic [NUM_IRQ-1:0] imr;
    logic               aeoi;
    logic               rotate_aeoi;
    logic               ack_first;
    logic               eoi_valid;
    logic               eoi_specific;
    logic               eoi_rotate;
    lvl_t               eoi_level;
    logic               int_req;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] isr;
    lvl_t               highest_pending;
    lvl_t               highest_isr;
    logic               spurious;

    // ack_first and eoi_valid are single-cycle pulses sampled on the rising clock edge; no back-pressure.
    modport master (
        output ir_in, ltim, imr, aeoi, rotate_aeoi, ack_first,
               eoi_valid, eoi_specific, eoi_rotate, eoi_level,
        input  int_req, irr, isr, highest_pending, highest_isr, spurious
    );

    modport slave (
        input  ir_in, ltim, imr, aeoi, rotate_aeoi, ack_first,
               eoi_valid, eoi_specific, eoi_rotate, eoi_level,
        output int_req, irr, isr, highest_pending, highest_isr, spurious
    );

endinterface

// File: rtl/pic_prio_encoder.sv
// Combinational rotating-priority encoder: picks the highest-priority set bit relative to lp.
module pic_prio_encoder
    import pic_pkg::*;
(
    input  logic [NUM_IRQ-1:0] vec,
    input  lvl_t               lp,
    output lvl_t               first,
    output logic               any
);

    assign first = rot_prio_first(vec, lp);
    assign any   = |vec;

endmodule

// File: rtl/pic_irq_resolver.sv
// 8259 interrupt request / in-service stage: IRR/ISR, masking, fixed or rotating priority, INT request.
// Optional macro PIC_IR_SYNC_EN adds a metastability flop ahead of the ir_s sampling stage.
module pic_irq_resolver
    import pic_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic               ltim,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               aeoi,
    input  logic               rotate_aeoi,
    input  logic               ack_first,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic               eoi_rotate,
    input  lvl_t               eoi_level,
    output logic               int_req,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr,
    output lvl_t               highest_pending,
    output lvl_t               highest_isr,
    output logic               spurious
);

    logic [NUM_IRQ-1:0] ir_s_q, ir_s_d;
    logic [NUM_IRQ-1:0] ir_d_q, ir_d_d;
    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    lvl_t               lp_q, lp_d;
    logic               int_req_q, int_req_d;
    logic               spurious_q, spurious_d;

`ifdef PIC_IR_SYNC_EN
    logic [NUM_IRQ-1:0] ir_meta_q, ir_meta_d;
`endif

    logic [NUM_IRQ-1:0] pend;
    lvl_t               hp, hi;
    logic               pend_any, isr_any;
    logic               ack_hit;
    logic [NUM_IRQ-1:0] ack_vec;
    logic               clr_valid;
    lvl_t               clr_lvl;

    assign pend = irr_q & ~imr;

    pic_prio_encoder u_pend_enc (
        .vec   (pend),
        .lp    (lp_q),
        .first (hp),
        .any   (pend_any)
    );

    pic_prio_encoder u_isr_enc (
        .vec   (isr_q),
        .lp    (lp_q),
        .first (hi),
        .any   (isr_any)
    );

    always_comb begin
`ifdef PIC_IR_SYNC_EN
        ir_meta_d = ir_in;
        ir_s_d    = ir_meta_q;
`else
        ir_s_d    = ir_in;
`endif
        ir_d_d  = ir_s_q;
        ack_hit = ack_first & pend_any;
        ack_vec = '0;
        if (ack_hit) ack_vec[hp] = 1'b1;

        // Edge mode: a fresh rising edge re-arms the bit even while its ack is clearing it.
        if (ltim) irr_d = ir_s_q;
        else      irr_d = (irr_q & ir_s_q & ~ack_vec) | (ir_s_q & ~ir_d_q);

        clr_valid = 1'b0;
        clr_lvl   = eoi_level;
        if (eoi_valid) begin
            if (eoi_specific) begin
                clr_valid = 1'b1;
            end else begin
                clr_valid = isr_any;
                clr_lvl   = hi;
            end
        end

        // EOI clear first, then ack set, so a same-cycle ack of the same level keeps the bit.
        isr_d = isr_q;
        if (clr_valid) isr_d[clr_lvl] = 1'b0;
        if (ack_hit && !aeoi) isr_d[hp] = 1'b1;

        lp_d = lp_q;
        if (clr_valid && eoi_rotate) lp_d = clr_lvl;
        if (ack_hit && aeoi && rotate_aeoi) lp_d = hp;

        int_req_d  = pend_any && (!isr_any || (prio_rank(hp, lp_q) < prio_rank(hi, lp_q)));
        spurious_d = ack_first && !pend_any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_s_q     <= '0;
            ir_d_q     <= '0;
            irr_q      <= '0;
            isr_q      <= '0;
            lp_q       <= LP_RESET;
            int_req_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            ir_s_q     <= ir_s_d;
            ir_d_q     <= ir_d_d;
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            lp_q       <= lp_d;
            int_req_q  <= int_req_d;
            spurious_q <= spurious_d;
        end
    end

`ifdef PIC_IR_SYNC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ir_meta_q <= '0;
        else        ir_meta_q <= ir_meta_d;
    end
`endif

    assign int_req         = int_req_q;
    assign irr             = irr_q;
    assign isr             = isr_q;
    assign highest_pending = hp;
    assign highest_isr     = hi;
    assign spurious        = spurious_q;

endmodule
